// File: rtl/riscv_pkg.sv
// Shared RISC-V datapath definitions: ALU op codes, branch funct3 codes,
// forwarding select encoding and default widths.
package riscv_pkg;

   localparam int XLEN_DEFAULT = 32;
   localparam int RA_W_DEFAULT = 5;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SUB  = 4'b0001,
      ALU_AND  = 4'b0010,
      ALU_OR   = 4'b0011,
      ALU_XOR  = 4'b0100,
      ALU_SLL  = 4'b0101,
      ALU_SRL  = 4'b0110,
      ALU_SRA  = 4'b0111,
      ALU_LUI  = 4'b1000,
      ALU_SLT  = 4'b1001,
      ALU_SLTU = 4'b1010
   } alu_op_t;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic [1:0] {
      FWD_REG = 2'b00,
      FWD_MEM = 2'b01,
      FWD_WB  = 2'b10
   } fwd_sel_t;

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding for one source register: picks EX/MEM result, MEM/WB
// write-back data or the registered operand. Loads only forward from WB.
module fwd_unit
   import riscv_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT,
   parameter int RA_W = RA_W_DEFAULT
) (
   input  logic [RA_W-1:0] src,
   input  logic [XLEN-1:0] reg_data,
   input  logic [RA_W-1:0] mem_rd,
   input  logic            mem_regwen,
   input  logic            mem_memread,
   input  logic [XLEN-1:0] mem_result,
   input  logic [RA_W-1:0] wb_rd,
   input  logic            wb_regwen,
   input  logic [XLEN-1:0] wb_data,
   output fwd_sel_t        sel,
   output logic [XLEN-1:0] fwd_data
);

   logic src_nz;
   logic mem_hit;
   logic wb_hit;

   assign src_nz  = (src != '0);
   // A load still in MEM has no data yet, so it is excluded from the MEM path.
   assign mem_hit = src_nz && mem_regwen && !mem_memread && (mem_rd == src);
   assign wb_hit  = src_nz && wb_regwen && (wb_rd == src);

   always_comb begin
      sel      = FWD_REG;
      fwd_data = reg_data;
      if (mem_hit) begin
         sel      = FWD_MEM;
         fwd_data = mem_result;
      end else if (wb_hit) begin
         sel      = FWD_WB;
         fwd_data = wb_data;
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding into the ALU, load-use
// hazard detection, IF/ID stall generation and bubble insertion.
module id_ex_stage
   import riscv_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT,
   parameter int RA_W = RA_W_DEFAULT
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            id_valid_i,
   input  logic [XLEN-1:0] id_pc_i,
   input  logic [XLEN-1:0] id_rs1_data_i,
   input  logic [XLEN-1:0] id_rs2_data_i,
   input  logic [XLEN-1:0] id_imm_i,
   input  logic [RA_W-1:0] id_rs1_i,
   input  logic [RA_W-1:0] id_rs2_i,
   input  logic [RA_W-1:0] id_rd_i,
   input  logic            id_rs1_used_i,
   input  logic            id_rs2_used_i,
   input  logic [3:0]      id_alu_ctrl_i,
   input  logic [2:0]      id_funct3_i,
   input  logic            id_asel_i,
   input  logic            id_bsel_i,
   input  logic            id_regwen_i,
   input  logic            id_memread_i,
   input  logic            id_memwrite_i,
   input  logic            id_branch_i,
   input  logic            id_jump_i,
   input  logic [RA_W-1:0] mem_rd_i,
   input  logic            mem_regwen_i,
   input  logic            mem_memread_i,
   input  logic [XLEN-1:0] mem_result_i,
   input  logic [RA_W-1:0] wb_rd_i,
   input  logic            wb_regwen_i,
   input  logic [XLEN-1:0] wb_data_i,
   input  logic            flush_i,
   input  logic            ex_hold_i,
   output logic [XLEN-1:0] operand_a_o,
   output logic [XLEN-1:0] operand_b_o,
   output logic [3:0]      alu_ctrl_o,
   output logic [2:0]      flagsel_o,
   output logic [XLEN-1:0] ex_store_data_o,
   output logic [XLEN-1:0] ex_pc_o,
   output logic [RA_W-1:0] ex_rd_o,
   output logic            ex_valid_o,
   output logic            ex_regwen_o,
   output logic            ex_memread_o,
   output logic            ex_memwrite_o,
   output logic            ex_branch_o,
   output logic            ex_jump_o,
   output logic            stall_o
);

   logic            vld_p1;
   logic            regwen_p1;
   logic            memread_p1;
   logic            memwrite_p1;
   logic            branch_p1;
   logic            jump_p1;
   logic [3:0]      alu_ctrl_p1;
   logic [XLEN-1:0] pc_p1;
   logic [XLEN-1:0] rs1_data_p1;
   logic [XLEN-1:0] rs2_data_p1;
   logic [XLEN-1:0] imm_p1;
   logic [RA_W-1:0] rs1_p1;
   logic [RA_W-1:0] rs2_p1;
   logic [RA_W-1:0] rd_p1;
   logic [2:0]      funct3_p1;
   logic            asel_p1;
   logic            bsel_p1;

   fwd_sel_t        fwd_a_sel;
   fwd_sel_t        fwd_b_sel;
   logic [XLEN-1:0] fwd_a_data;
   logic [XLEN-1:0] fwd_b_data;
   logic            load_use;
   logic            bubble;

   assign load_use = vld_p1 && memread_p1 && (rd_p1 != '0) &&
                     ((id_rs1_used_i && (id_rs1_i == rd_p1)) ||
                      (id_rs2_used_i && (id_rs2_i == rd_p1)));
   assign stall_o  = load_use || ex_hold_i;
   assign bubble   = load_use || !id_valid_i;

   // ---- ID -> EX boundary: control registers ----
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         vld_p1      <= 1'b0;
         regwen_p1   <= 1'b0;
         memread_p1  <= 1'b0;
         memwrite_p1 <= 1'b0;
         branch_p1   <= 1'b0;
         jump_p1     <= 1'b0;
         alu_ctrl_p1 <= ALU_ADD;
      end else if (flush_i || (!ex_hold_i && bubble)) begin
         vld_p1      <= 1'b0;
         regwen_p1   <= 1'b0;
         memread_p1  <= 1'b0;
         memwrite_p1 <= 1'b0;
         branch_p1   <= 1'b0;
         jump_p1     <= 1'b0;
         alu_ctrl_p1 <= ALU_ADD;
      end else if (!ex_hold_i) begin
         vld_p1      <= 1'b1;
         regwen_p1   <= id_regwen_i;
         memread_p1  <= id_memread_i;
         memwrite_p1 <= id_memwrite_i;
         branch_p1   <= id_branch_i;
         jump_p1     <= id_jump_i;
         alu_ctrl_p1 <= id_alu_ctrl_i;
      end
   end

   // ---- ID -> EX boundary: data registers ----
   // While held, the operand registers absorb any forwarded value so a
   // producer that retires from MEM/WB during the hold is not lost.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         pc_p1       <= '0;
         rs1_data_p1 <= '0;
         rs2_data_p1 <= '0;
         imm_p1      <= '0;
         rs1_p1      <= '0;
         rs2_p1      <= '0;
         rd_p1       <= '0;
         funct3_p1   <= '0;
         asel_p1     <= 1'b0;
         bsel_p1     <= 1'b0;
      end else if (ex_hold_i && !flush_i) begin
         rs1_data_p1 <= (fwd_a_sel == FWD_REG) ? rs1_data_p1 : fwd_a_data;
         rs2_data_p1 <= (fwd_b_sel == FWD_REG) ? rs2_data_p1 : fwd_b_data;
      end else begin
         pc_p1       <= id_pc_i;
         rs1_data_p1 <= id_rs1_data_i;
         rs2_data_p1 <= id_rs2_data_i;
         imm_p1      <= id_imm_i;
         rs1_p1      <= id_rs1_i;
         rs2_p1      <= id_rs2_i;
         rd_p1       <= id_rd_i;
         funct3_p1   <= id_funct3_i;
         asel_p1     <= id_asel_i;
         bsel_p1     <= id_bsel_i;
      end
   end

   fwd_unit #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_a (
      .src         (rs1_p1),
      .reg_data    (rs1_data_p1),
      .mem_rd      (mem_rd_i),
      .mem_regwen  (mem_regwen_i),
      .mem_memread (mem_memread_i),
      .mem_result  (mem_result_i),
      .wb_rd       (wb_rd_i),
      .wb_regwen   (wb_regwen_i),
      .wb_data     (wb_data_i),
      .sel         (fwd_a_sel),
      .fwd_data    (fwd_a_data)
   );

   fwd_unit #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_b (
      .src         (rs2_p1),
      .reg_data    (rs2_data_p1),
      .mem_rd      (mem_rd_i),
      .mem_regwen  (mem_regwen_i),
      .mem_memread (mem_memread_i),
      .mem_result  (mem_result_i),
      .wb_rd       (wb_rd_i),
      .wb_regwen   (wb_regwen_i),
      .wb_data     (wb_data_i),
      .sel         (fwd_b_sel),
      .fwd_data    (fwd_b_data)
   );

   // ---- EX outputs ----
   assign operand_a_o     = asel_p1 ? pc_p1 : fwd_a_data;
   assign operand_b_o     = bsel_p1 ? imm_p1 : fwd_b_data;
   assign ex_store_data_o = fwd_b_data;
   assign alu_ctrl_o      = alu_ctrl_p1;
   assign flagsel_o       = funct3_p1;
   assign ex_pc_o         = pc_p1;
   assign ex_rd_o         = rd_p1;
   assign ex_valid_o      = vld_p1;
   assign ex_regwen_o     = regwen_p1;
   assign ex_memread_o    = memread_p1;
   assign ex_memwrite_o   = memwrite_p1;
   assign ex_branch_o     = branch_p1;
   assign ex_jump_o       = jump_p1;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a forwarding vector table plus hand-written
// reset, load-use, flush and hold sequences.
module tb_id_ex_stage;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        id_valid_i;
   logic [31:0] id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i;
   logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
   logic        id_rs1_used_i, id_rs2_used_i;
   logic [3:0]  id_alu_ctrl_i;
   logic [2:0]  id_funct3_i;
   logic        id_asel_i, id_bsel_i;
   logic        id_regwen_i, id_memread_i, id_memwrite_i, id_branch_i, id_jump_i;
   logic [4:0]  mem_rd_i;
   logic        mem_regwen_i, mem_memread_i;
   logic [31:0] mem_result_i;
   logic [4:0]  wb_rd_i;
   logic        wb_regwen_i;
   logic [31:0] wb_data_i;
   logic        flush_i, ex_hold_i;
   logic [31:0] operand_a_o, operand_b_o, ex_store_data_o, ex_pc_o;
   logic [3:0]  alu_ctrl_o;
   logic [2:0]  flagsel_o;
   logic [4:0]  ex_rd_o;
   logic        ex_valid_o, ex_regwen_o, ex_memread_o, ex_memwrite_o;
   logic        ex_branch_o, ex_jump_o, stall_o;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk_i = ~clk_i;

   id_ex_stage dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .id_valid_i(id_valid_i), .id_pc_i(id_pc_i),
      .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i), .id_imm_i(id_imm_i),
      .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
      .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
      .id_alu_ctrl_i(id_alu_ctrl_i), .id_funct3_i(id_funct3_i),
      .id_asel_i(id_asel_i), .id_bsel_i(id_bsel_i),
      .id_regwen_i(id_regwen_i), .id_memread_i(id_memread_i), .id_memwrite_i(id_memwrite_i),
      .id_branch_i(id_branch_i), .id_jump_i(id_jump_i),
      .mem_rd_i(mem_rd_i), .mem_regwen_i(mem_regwen_i), .mem_memread_i(mem_memread_i),
      .mem_result_i(mem_result_i), .wb_rd_i(wb_rd_i), .wb_regwen_i(wb_regwen_i),
      .wb_data_i(wb_data_i), .flush_i(flush_i), .ex_hold_i(ex_hold_i),
      .operand_a_o(operand_a_o), .operand_b_o(operand_b_o), .alu_ctrl_o(alu_ctrl_o),
      .flagsel_o(flagsel_o), .ex_store_data_o(ex_store_data_o), .ex_pc_o(ex_pc_o),
      .ex_rd_o(ex_rd_o), .ex_valid_o(ex_valid_o), .ex_regwen_o(ex_regwen_o),
      .ex_memread_o(ex_memread_o), .ex_memwrite_o(ex_memwrite_o),
      .ex_branch_o(ex_branch_o), .ex_jump_o(ex_jump_o), .stall_o(stall_o)
   );

   typedef struct {
      string       name;
      logic        asel, bsel;
      logic [31:0] pc, imm;
      logic [4:0]  rs1;
      logic [31:0] rs1d;
      logic [4:0]  rs2;
      logic [31:0] rs2d;
      logic [3:0]  alu;
      logic [2:0]  f3;
      logic [4:0]  mrd;
      logic        mwen, mload;
      logic [31:0] mres;
      logic [4:0]  wrd;
      logic        wwen;
      logic [31:0] wdat;
      logic [31:0] exp_a, exp_b, exp_st;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      id_valid_i = 0; id_pc_i = 0; id_rs1_data_i = 0; id_rs2_data_i = 0; id_imm_i = 0;
      id_rs1_i = 0; id_rs2_i = 0; id_rd_i = 0; id_rs1_used_i = 0; id_rs2_used_i = 0;
      id_alu_ctrl_i = 0; id_funct3_i = 0; id_asel_i = 0; id_bsel_i = 0;
      id_regwen_i = 0; id_memread_i = 0; id_memwrite_i = 0; id_branch_i = 0; id_jump_i = 0;
      mem_rd_i = 0; mem_regwen_i = 0; mem_memread_i = 0; mem_result_i = 0;
      wb_rd_i = 0; wb_regwen_i = 0; wb_data_i = 0; flush_i = 0; ex_hold_i = 0;
   endtask

   task automatic drive_alu(input logic [4:0] rs1, input logic [31:0] rs1d,
                            input logic [4:0] rs2, input logic [31:0] rs2d,
                            input logic [4:0] rd, input logic [3:0] alu);
      id_valid_i = 1; id_rs1_i = rs1; id_rs1_data_i = rs1d; id_rs2_i = rs2;
      id_rs2_data_i = rs2d; id_rd_i = rd; id_alu_ctrl_i = alu;
      id_rs1_used_i = 1; id_rs2_used_i = 1; id_regwen_i = 1; id_memread_i = 0;
   endtask

   initial begin
      //            name             as bs pc        imm           rs1 rs1d rs2 rs2d alu    f3    mrd mw ml mres   wrd ww wdat   a      b             st
      vecs[0] = '{"add_plain",       0, 0, 32'h40,  32'h10,       1,  5,   2,  7,   4'h0, 3'd0, 0,  0, 0, 0,     0,  0, 0,     5,     7,            7};
      vecs[1] = '{"mem_fwd_a",       0, 0, 32'h44,  32'h10,       3,  0,   1,  5,   4'h0, 3'd0, 3,  1, 0, 12,    0,  0, 0,     12,    5,            5};
      vecs[2] = '{"mem_over_wb",     0, 0, 32'h48,  32'h10,       3,  0,   3,  0,   4'h0, 3'd0, 3,  1, 0, 12,    3,  1, 99,    12,    12,           12};
      vecs[3] = '{"wb_fwd_b",        0, 0, 32'h4C,  32'h10,       1,  5,   2,  0,   4'h1, 3'd1, 0,  0, 0, 0,     2,  1, 99,    5,     99,           99};
      vecs[4] = '{"x0_never",        0, 0, 32'h50,  32'h10,       0,  0,   0,  0,   4'h0, 3'd0, 0,  1, 0, 123,   0,  1, 77,    0,     0,            0};
      vecs[5] = '{"load_in_mem",     0, 0, 32'h54,  32'h10,       3,  1,   4,  2,   4'h4, 3'd4, 3,  1, 1, 32'h55, 3, 1, 32'h66, 32'h66, 2,           2};
      vecs[6] = '{"sel_pc_imm",      1, 1, 32'h100, 32'hFFFFFFFC, 1,  5,   2,  7,   4'h0, 3'd0, 2,  1, 0, 32'h33, 0, 0, 0,     32'h100, 32'hFFFFFFFC, 32'h33};
      vecs[7] = '{"regwen_off",      0, 0, 32'h58,  32'h10,       1,  5,   2,  7,   4'h8, 3'd7, 1,  0, 0, 32'h44, 2, 0, 32'h88, 5,     7,            7};

      // Reset held two cycles with a valid instruction on ID.
      idle();
      rst_ni = 0;
      drive_alu(1, 5, 2, 7, 3, 4'h1);
      id_memread_i = 1;
      step();
      step();
      chk("rst_valid",   32'(ex_valid_o),   0);
      chk("rst_stall",   32'(stall_o),      0);
      chk("rst_regwen",  32'(ex_regwen_o),  0);
      chk("rst_memread", 32'(ex_memread_o), 0);
      chk("rst_alu",     32'(alu_ctrl_o),   0);
      chk("rst_pc",      ex_pc_o,           0);
      rst_ni = 1;
      idle();
      step();

      // Forwarding table: capture one instruction, then present sources.
      for (int i = 0; i < 8; i++) begin
         idle();
         drive_alu(vecs[i].rs1, vecs[i].rs1d, vecs[i].rs2, vecs[i].rs2d, 5'd9, vecs[i].alu);
         id_asel_i = vecs[i].asel; id_bsel_i = vecs[i].bsel;
         id_pc_i = vecs[i].pc; id_imm_i = vecs[i].imm; id_funct3_i = vecs[i].f3;
         step();
         idle();
         mem_rd_i = vecs[i].mrd; mem_regwen_i = vecs[i].mwen;
         mem_memread_i = vecs[i].mload; mem_result_i = vecs[i].mres;
         wb_rd_i = vecs[i].wrd; wb_regwen_i = vecs[i].wwen; wb_data_i = vecs[i].wdat;
         #1;
         chk({vecs[i].name, "_a"},     operand_a_o,        vecs[i].exp_a);
         chk({vecs[i].name, "_b"},     operand_b_o,        vecs[i].exp_b);
         chk({vecs[i].name, "_st"},    ex_store_data_o,    vecs[i].exp_st);
         chk({vecs[i].name, "_alu"},   32'(alu_ctrl_o),    32'(vecs[i].alu));
         chk({vecs[i].name, "_f3"},    32'(flagsel_o),     32'(vecs[i].f3));
         chk({vecs[i].name, "_valid"}, 32'(ex_valid_o),    1);
         step();
      end

      // Load-use: lw x5 in EX, add x6,x5,x1 waits one cycle, then takes WB data.
      idle();
      drive_alu(1, 0, 0, 0, 5, 4'h0);
      id_memread_i = 1; id_rs2_used_i = 0;
      step();
      idle();
      drive_alu(5, 0, 1, 5, 6, 4'h0);
      #1;
      chk("lu_stall", 32'(stall_o), 1);
      step();
      mem_rd_i = 5; mem_regwen_i = 1; mem_memread_i = 1; mem_result_i = 32'h1234;
      #1;
      chk("lu_bubble_valid", 32'(ex_valid_o),   0);
      chk("lu_bubble_mrd",   32'(ex_memread_o), 0);
      chk("lu_stall_drop",   32'(stall_o),      0);
      step();
      idle();
      wb_rd_i = 5; wb_regwen_i = 1; wb_data_i = 32'hDEAD;
      #1;
      chk("lu_fwd_a", operand_a_o,       32'hDEAD);
      chk("lu_b",     operand_b_o,       5);
      chk("lu_rd",    32'(ex_rd_o),      6);
      chk("lu_valid", 32'(ex_valid_o),   1);
      step();

      // Flush kills a valid sub entering EX.
      idle();
      drive_alu(1, 5, 2, 7, 3, 4'h1);
      flush_i = 1;
      step();
      idle();
      #1;
      chk("fl_valid",  32'(ex_valid_o),  0);
      chk("fl_regwen", 32'(ex_regwen_o), 0);
      chk("fl_alu",    32'(alu_ctrl_o),  0);

      // Flush together with load-use: stall follows its equation, EX gets a bubble.
      drive_alu(1, 0, 0, 0, 5, 4'h0);
      id_memread_i = 1;
      step();
      idle();
      drive_alu(2, 0, 5, 0, 6, 4'h0);
      flush_i = 1;
      #1;
      chk("fllu_stall", 32'(stall_o), 1);
      step();
      idle();
      #1;
      chk("fllu_valid", 32'(ex_valid_o), 0);
      chk("fllu_stall_drop", 32'(stall_o), 0);

      // Hold for three edges while a WB forward retires after the first.
      drive_alu(8, 1, 9, 2, 7, 4'h4);
      step();
      idle();
      ex_hold_i = 1;
      wb_rd_i = 8; wb_regwen_i = 1; wb_data_i = 32'hBEEF;
      drive_alu(1, 3, 2, 4, 10, 4'h1);
      #1;
      chk("hold_a0",     operand_a_o,    32'hBEEF);
      chk("hold_stall",  32'(stall_o),   1);
      step();
      wb_regwen_i = 0;
      #1;
      chk("hold_a1",     operand_a_o,    32'hBEEF);
      chk("hold_rd1",    32'(ex_rd_o),   7);
      chk("hold_alu1",   32'(alu_ctrl_o), 4);
      chk("hold_valid1", 32'(ex_valid_o), 1);
      step();
      #1;
      chk("hold_a2",     operand_a_o,    32'hBEEF);
      chk("hold_b2",     operand_b_o,    2);
      step();
      ex_hold_i = 0;
      idle();
      #1;
      chk("hold_a3",     operand_a_o,    32'hBEEF);
      chk("hold_rd3",    32'(ex_rd_o),   7);
      chk("hold_unstall", 32'(stall_o),  0);
      step();
      chk("hold_release", 32'(ex_valid_o), 0);

      // Reset in the middle of a load-use stall.
      drive_alu(1, 0, 0, 0, 5, 4'h0);
      id_memread_i = 1;
      step();
      idle();
      drive_alu(5, 0, 1, 0, 6, 4'h0);
      #1;
      chk("rs_stall", 32'(stall_o), 1);
      rst_ni = 0;
      step();
      rst_ni = 1;
      #1;
      chk("rs_valid",      32'(ex_valid_o), 0);
      chk("rs_stall_drop", 32'(stall_o),    0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
